// File: rtl/system_top_cmul_pipe.sv
// system_top_cmul_pipe
// Pipelined signed complex multiplier: P = A*B or A*conj(B) per transaction.
// The result is shifted right with round-half-up and clamped to dout_WIDTH.
// A valid/ready handshake stalls the whole pipeline at once, and bubbles are kept.
module system_top_cmul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 16,
    parameter int SHIFT      = 15
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [din0_WIDTH-1:0] a_re,
    input  logic signed [din0_WIDTH-1:0] a_im,
    input  logic signed [din1_WIDTH-1:0] b_re,
    input  logic signed [din1_WIDTH-1:0] b_im,
    input  logic                         conj_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [dout_WIDTH-1:0] p_re,
    output logic signed [dout_WIDTH-1:0] p_im,
    output logic                         p_sat
);

    // Product width, full-precision sum width, and the rounding bias bit position.
    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int FW = PW + 1;
    localparam int RB = (SHIFT > 0) ? SHIFT - 1 : 0;
    // Clamp comparison width: wide enough for both the rounded sum and the output range.
    localparam int WW = ((FW + 1 > dout_WIDTH) ? FW + 1 : dout_WIDTH) + 1;
    // Number of product-holding registers (stage 2 up to the stage before the output).
    localparam int PD = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 1;

    // Exact signed product; both operands are widened to PW so nothing is lost.
    function automatic logic signed [PW-1:0] mul(
        input logic signed [din0_WIDTH-1:0] a,
        input logic signed [din1_WIDTH-1:0] b
    );
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax = $signed({{din1_WIDTH{a[din0_WIDTH-1]}}, a});
        bx = $signed({{din0_WIDTH{b[din1_WIDTH-1]}}, b});
        return ax * bx;
    endfunction

    // Sign-extend a product by one bit so that the sum of two products cannot wrap.
    function automatic logic signed [FW-1:0] ext(input logic signed [PW-1:0] p);
        return $signed({p[PW-1], p});
    endfunction

    // Real part: conjugation flips the sign of the a_im*b_im term, not of b_im itself.
    function automatic logic signed [FW-1:0] sum_re(
        input logic signed [PW-1:0] rr,
        input logic signed [PW-1:0] ii,
        input logic                 conj
    );
        return conj ? (ext(rr) + ext(ii)) : (ext(rr) - ext(ii));
    endfunction

    // Imaginary part: conjugation flips the sign of the a_re*b_im term.
    function automatic logic signed [FW-1:0] sum_im(
        input logic signed [PW-1:0] ri,
        input logic signed [PW-1:0] ir,
        input logic                 conj
    );
        return conj ? (ext(ir) - ext(ri)) : (ext(ir) + ext(ri));
    endfunction

    // Round half toward +inf and shift; one guard bit keeps the bias add from wrapping.
    function automatic logic signed [FW:0] rnd_shift(input logic signed [FW-1:0] x);
        logic signed [FW:0] xe;
        logic signed [FW:0] bias;
        xe   = $signed({x[FW-1], x});
        bias = '0;
        if (SHIFT > 0) begin
            bias[RB] = 1'b1;
        end
        return (xe + bias) >>> SHIFT;
    endfunction

    // Clamp to the output range; the MSB of the result is the clamp flag.
    function automatic logic [dout_WIDTH:0] sat_clamp(input logic signed [FW:0] r);
        logic signed [WW-1:0] rx;
        logic signed [WW-1:0] maxv;
        logic signed [WW-1:0] minv;
        rx                     = $signed({{(WW-FW-1){r[FW]}}, r});
        maxv                   = '0;
        maxv[dout_WIDTH-2:0]   = '1;
        minv                   = ~maxv;
        if (rx > maxv) begin
            return {1'b1, maxv[dout_WIDTH-1:0]};
        end else if (rx < minv) begin
            return {1'b1, minv[dout_WIDTH-1:0]};
        end else begin
            return {1'b0, rx[dout_WIDTH-1:0]};
        end
    endfunction

    // Parameter sets outside the supported range land in this visibly named empty block.
    generate
        if (ID < 0 || NUM_STAGE < 1 || NUM_STAGE > 6 || SHIFT < 0 || SHIFT > PW || dout_WIDTH < 2)
        begin : g_unsupported_parameters
        end
    endgenerate

    logic                          w_en;
    logic signed [din0_WIDTH-1:0]  w_are_s;
    logic signed [din0_WIDTH-1:0]  w_aim_s;
    logic signed [din1_WIDTH-1:0]  w_bre_s;
    logic signed [din1_WIDTH-1:0]  w_bim_s;
    logic                          w_conj_s;
    logic                          w_vld_s;
    logic signed [PW-1:0]          w_rr_q;
    logic signed [PW-1:0]          w_ii_q;
    logic signed [PW-1:0]          w_ri_q;
    logic signed [PW-1:0]          w_ir_q;
    logic                          w_conj_q;
    logic                          w_vld_q;
    logic signed [FW-1:0]          w_re_full;
    logic signed [FW-1:0]          w_im_full;
    logic [dout_WIDTH:0]           w_re_rs;
    logic [dout_WIDTH:0]           w_im_rs;
    logic signed [dout_WIDTH-1:0]  r_re_pout;
    logic signed [dout_WIDTH-1:0]  r_im_pout;
    logic                          r_sat_pout;
    logic                          r_vld_pout;

    // The pipeline moves as a whole whenever the output slot is empty or being drained.
    assign w_en     = ~r_vld_pout | out_ready;
    assign in_ready = w_en;

    generate
        if (NUM_STAGE == 1) begin : g_no_in_reg
            // Single-register pipeline: the output register is fed straight from the ports.
            assign w_are_s  = a_re;
            assign w_aim_s  = a_im;
            assign w_bre_s  = b_re;
            assign w_bim_s  = b_im;
            assign w_conj_s = conj_b;
            assign w_vld_s  = in_valid;
        end else begin : g_in_reg
            logic signed [din0_WIDTH-1:0] r_are_p1;
            logic signed [din0_WIDTH-1:0] r_aim_p1;
            logic signed [din1_WIDTH-1:0] r_bre_p1;
            logic signed [din1_WIDTH-1:0] r_bim_p1;
            logic                         r_conj_p1;
            logic                         r_vld_p1;

            // Stage 1: capture the operands, the conjugate flag and the valid bit.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    r_are_p1  <= '0;
                    r_aim_p1  <= '0;
                    r_bre_p1  <= '0;
                    r_bim_p1  <= '0;
                    r_conj_p1 <= 1'b0;
                    r_vld_p1  <= 1'b0;
                end else if (w_en) begin
                    r_are_p1  <= a_re;
                    r_aim_p1  <= a_im;
                    r_bre_p1  <= b_re;
                    r_bim_p1  <= b_im;
                    r_conj_p1 <= conj_b;
                    r_vld_p1  <= in_valid;
                end
            end

            assign w_are_s  = r_are_p1;
            assign w_aim_s  = r_aim_p1;
            assign w_bre_s  = r_bre_p1;
            assign w_bim_s  = r_bim_p1;
            assign w_conj_s = r_conj_p1;
            assign w_vld_s  = r_vld_p1;
        end

        if (NUM_STAGE >= 3) begin : g_prod_reg
            logic signed [PW-1:0] r_rr_p2   [PD];
            logic signed [PW-1:0] r_ii_p2   [PD];
            logic signed [PW-1:0] r_ri_p2   [PD];
            logic signed [PW-1:0] r_ir_p2   [PD];
            logic                 r_conj_p2 [PD];
            logic                 r_vld_p2  [PD];

            // Stage 2 registers the four partial products; later entries are balancing delay.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int k = 0; k < PD; k++) begin
                        r_rr_p2[k]   <= '0;
                        r_ii_p2[k]   <= '0;
                        r_ri_p2[k]   <= '0;
                        r_ir_p2[k]   <= '0;
                        r_conj_p2[k] <= 1'b0;
                        r_vld_p2[k]  <= 1'b0;
                    end
                end else if (w_en) begin
                    r_rr_p2[0]   <= mul(w_are_s, w_bre_s);
                    r_ii_p2[0]   <= mul(w_aim_s, w_bim_s);
                    r_ri_p2[0]   <= mul(w_are_s, w_bim_s);
                    r_ir_p2[0]   <= mul(w_aim_s, w_bre_s);
                    r_conj_p2[0] <= w_conj_s;
                    r_vld_p2[0]  <= w_vld_s;
                    for (int k = 1; k < PD; k++) begin
                        r_rr_p2[k]   <= r_rr_p2[k-1];
                        r_ii_p2[k]   <= r_ii_p2[k-1];
                        r_ri_p2[k]   <= r_ri_p2[k-1];
                        r_ir_p2[k]   <= r_ir_p2[k-1];
                        r_conj_p2[k] <= r_conj_p2[k-1];
                        r_vld_p2[k]  <= r_vld_p2[k-1];
                    end
                end
            end

            assign w_rr_q   = r_rr_p2[PD-1];
            assign w_ii_q   = r_ii_p2[PD-1];
            assign w_ri_q   = r_ri_p2[PD-1];
            assign w_ir_q   = r_ir_p2[PD-1];
            assign w_conj_q = r_conj_p2[PD-1];
            assign w_vld_q  = r_vld_p2[PD-1];
        end else begin : g_prod_comb
            // Short pipelines fold the products into the output stage.
            assign w_rr_q   = mul(w_are_s, w_bre_s);
            assign w_ii_q   = mul(w_aim_s, w_bim_s);
            assign w_ri_q   = mul(w_are_s, w_bim_s);
            assign w_ir_q   = mul(w_aim_s, w_bre_s);
            assign w_conj_q = w_conj_s;
            assign w_vld_q  = w_vld_s;
        end
    endgenerate

    assign w_re_full = sum_re(w_rr_q, w_ii_q, w_conj_q);
    assign w_im_full = sum_im(w_ri_q, w_ir_q, w_conj_q);
    assign w_re_rs   = sat_clamp(rnd_shift(w_re_full));
    assign w_im_rs   = sat_clamp(rnd_shift(w_im_full));

    // Final stage: register the rounded, clamped result with its flag and valid bit.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_re_pout  <= '0;
            r_im_pout  <= '0;
            r_sat_pout <= 1'b0;
            r_vld_pout <= 1'b0;
        end else if (w_en) begin
            r_re_pout  <= w_re_rs[dout_WIDTH-1:0];
            r_im_pout  <= w_im_rs[dout_WIDTH-1:0];
            r_sat_pout <= w_re_rs[dout_WIDTH] | w_im_rs[dout_WIDTH];
            r_vld_pout <= w_vld_q;
        end
    end

    assign out_valid = r_vld_pout;
    assign p_re      = r_re_pout;
    assign p_im      = r_im_pout;
    assign p_sat     = r_sat_pout;

endmodule
